// File: rtl/ras_ckpt_restore_pkg.sv
// Shared sizes, FSM encoding and the checkpoint image layout for the return-stack restore path.
package ras_ckpt_restore_pkg;
  localparam int STACKPTRW  = 4;
  localparam int STACKWIDE  = 32;
  localparam int RECURCOUNT = 7;
  localparam int LW         = STACKWIDE + RECURCOUNT;
  localparam int LINES      = 15;
  localparam int CKPTNUM    = 4;
  localparam int CKPTW      = 2;
  localparam int IDXW       = 4;

  typedef logic [CKPTW-1:0] slot_t;
  typedef logic [CKPTW:0]   cnt_t;
  typedef logic [IDXW-1:0]  idx_t;

  localparam cnt_t FULL_CNT = cnt_t'(CKPTNUM);
  localparam idx_t LAST_IDX = idx_t'(LINES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } rs_state_e;

  typedef struct packed {
    logic [STACKPTRW-1:0] ptr;
    logic [LINES*LW-1:0]  lines;
  } ckpt_t;
endpackage

// File: rtl/ras_ckpt_ram.sv
// Checkpoint image store: one write port, one combinational read port, contents not reset.
module ras_ckpt_ram
  import ras_ckpt_restore_pkg::*;
(
  input  logic  Clk,
  input  logic  we,
  input  slot_t waddr,
  input  ckpt_t wdata,
  input  slot_t raddr,
  output ckpt_t rdata
);
  ckpt_t mem [CKPTNUM];

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/ras_ckpt_restore.sv
// Circular checkpoint buffer of return-stack images; streams a selected image back on redirect.
module ras_ckpt_restore
  import ras_ckpt_restore_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rest,
  input  logic                  SNAPVALID,
  input  logic [STACKPTRW-1:0]  SNAPPTR,
  input  logic [LINES*LW-1:0]   SNAPLINES,
  output logic [CKPTW-1:0]      SNAPID,
  output logic                  CKPTFULL,
  input  logic                  COMMIT,
  input  logic                  RESTORE,
  input  logic [CKPTW-1:0]      RESTOREID,
  output logic                  RESTVALID,
  input  logic                  RESTREADY,
  output logic [3:0]            RESTIDX,
  output logic [LW-1:0]         RESTLINE,
  output logic                  RESTDONE,
  output logic [STACKPTRW-1:0]  RESTPTR,
  output logic                  RESTERR,
  output logic                  OVERFLOW
);
  rs_state_e state_q, state_d;
  slot_t     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, sel_q, sel_d, rel;
  cnt_t      count_q, count_d, base_cnt;
  idx_t      idx_q, idx_d;
  logic      err_q, err_d, ovf_q, ovf_d;
  logic      restore_ok, protect, commit_ok, cap_try, cap_ok;
  ckpt_t     wr_img, rd_img;
  logic [LW-1:0] line_sel;

  always_comb begin
    rel        = RESTOREID - rd_ptr_q;
    restore_ok = RESTORE && (count_q != '0) && ({1'b0, rel} < count_q);
    base_cnt   = restore_ok ? ({1'b0, rel} + cnt_t'(1)) : count_q;
    // The slot being restored must survive a COMMIT until the stack has it back.
    protect    = restore_ok ? (rd_ptr_q == RESTOREID)
                            : ((state_q != IDLE) && (rd_ptr_q == sel_q));
    commit_ok  = COMMIT && (base_cnt != '0) && !protect;
    cap_try    = SNAPVALID && (state_q == IDLE) && !restore_ok;
    // A same-cycle COMMIT frees the oldest slot, so a full buffer can still accept.
    cap_ok     = cap_try && ((count_q != FULL_CNT) || commit_ok);

    wr_ptr_d = restore_ok ? (RESTOREID + slot_t'(1)) : (wr_ptr_q + slot_t'(cap_ok));
    rd_ptr_d = rd_ptr_q + slot_t'(commit_ok);
    count_d  = base_cnt + cnt_t'(cap_ok) - cnt_t'(commit_ok);
    err_d    = RESTORE && !restore_ok;
    ovf_d    = ovf_q || (cap_try && !cap_ok);

    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    if (restore_ok) begin
      state_d = STREAM;
      sel_d   = RESTOREID;
      idx_d   = '0;
    end else begin
      case (state_q)
        STREAM: if (RESTREADY) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + idx_t'(1);
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sel_q    <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sel_q    <= sel_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wr_img = ckpt_t'{SNAPPTR, SNAPLINES};

  ras_ckpt_ram u_ram (
    .Clk   (Clk),
    .we    (cap_ok),
    .waddr (wr_ptr_q),
    .wdata (wr_img),
    .raddr (sel_q),
    .rdata (rd_img)
  );

  always_comb begin
    line_sel = '0;
    for (int k = 0; k < LINES; k++) begin
      if (idx_q == idx_t'(k)) line_sel = rd_img.lines[k*LW +: LW];
    end
  end

  assign SNAPID    = wr_ptr_q;
  assign CKPTFULL  = (count_q == FULL_CNT);
  assign RESTVALID = (state_q == STREAM);
  assign RESTIDX   = idx_q;
  assign RESTLINE  = RESTVALID ? line_sel : '0;
  assign RESTDONE  = (state_q == DONE);
  assign RESTPTR   = RESTDONE ? rd_img.ptr : '0;
  assign RESTERR   = err_q;
  assign OVERFLOW  = ovf_q;
endmodule

// File: tb/tb_ras_ckpt_restore.sv
// Bench for ras_ckpt_restore: vector table, directed restore sequences, random run against a queue model.
module tb_ras_ckpt_restore;
  import ras_ckpt_restore_pkg::*;

  logic                 Clk = 1'b0;
  logic                 Rest = 1'b1;
  logic                 SNAPVALID = 1'b0;
  logic [STACKPTRW-1:0] SNAPPTR = '0;
  logic [LINES*LW-1:0]  SNAPLINES = '0;
  logic [CKPTW-1:0]     SNAPID;
  logic                 CKPTFULL;
  logic                 COMMIT = 1'b0;
  logic                 RESTORE = 1'b0;
  logic [CKPTW-1:0]     RESTOREID = '0;
  logic                 RESTVALID;
  logic                 RESTREADY = 1'b0;
  logic [3:0]           RESTIDX;
  logic [LW-1:0]        RESTLINE;
  logic                 RESTDONE;
  logic [STACKPTRW-1:0] RESTPTR;
  logic                 RESTERR;
  logic                 OVERFLOW;

  int checks = 0;
  int failures = 0;

  ras_ckpt_restore dut (
    .Clk(Clk), .Rest(Rest), .SNAPVALID(SNAPVALID), .SNAPPTR(SNAPPTR), .SNAPLINES(SNAPLINES),
    .SNAPID(SNAPID), .CKPTFULL(CKPTFULL), .COMMIT(COMMIT), .RESTORE(RESTORE),
    .RESTOREID(RESTOREID), .RESTVALID(RESTVALID), .RESTREADY(RESTREADY), .RESTIDX(RESTIDX),
    .RESTLINE(RESTLINE), .RESTDONE(RESTDONE), .RESTPTR(RESTPTR), .RESTERR(RESTERR),
    .OVERFLOW(OVERFLOW)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit       rst, snap;
    bit [3:0] sptr;
    bit       commit, rest;
    bit [1:0] rid;
    bit       rdy;
    bit [1:0] e_id;
    bit       e_full, e_err, e_ovf, e_vld;
  } vec_t;

  function automatic vec_t mkv(int rs, int sn, int sp, int cm, int re, int ri, int rd,
                               int id, int fu, int er, int ov, int vl);
    vec_t v;
    v.rst = rs[0]; v.snap = sn[0]; v.sptr = 4'(sp); v.commit = cm[0]; v.rest = re[0];
    v.rid = 2'(ri); v.rdy = rd[0]; v.e_id = 2'(id); v.e_full = fu[0]; v.e_err = er[0];
    v.e_ovf = ov[0]; v.e_vld = vl[0];
    return v;
  endfunction

  function automatic logic [LINES*LW-1:0] mk_lines(int s);
    logic [LINES*LW-1:0] img;
    for (int k = 0; k < LINES; k++)
      img[k*LW +: LW] = {7'(s + k), 32'(s * 32'h01000193 + k)};
    return img;
  endfunction

  function automatic logic [LW-1:0] line_of(logic [LINES*LW-1:0] img, int k);
    return img[k*LW +: LW];
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    SNAPVALID = 1'b0; COMMIT = 1'b0; RESTORE = 1'b0; RESTOREID = '0;
  endtask

  task automatic snap(int p, logic [LINES*LW-1:0] img);
    SNAPVALID = 1'b1; SNAPPTR = 4'(p); SNAPLINES = img;
    step();
    SNAPVALID = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({SNAPID, CKPTFULL, RESTVALID, RESTIDX, RESTLINE, RESTDONE, RESTPTR, RESTERR, OVERFLOW});
  endfunction

  task automatic do_reset(string nm);
    clr();
    RESTREADY = 1'b0;
    Rest = 1'b0;
    #1;
    check(nm, all_outs(), 64'd0);
    #1;
    Rest = 1'b1;
    step();
  endtask

  vec_t tbl[14];

  // queue model: live slots oldest-first
  int q[$];
  int wr, mode, msel, midx;
  bit merr, movf;
  logic [3:0] mptr[4];
  logic [LINES*LW-1:0] mimg[4];

  initial begin
    logic [LINES*LW-1:0] img;
    int n, dones;
    bit [3:0] rpat [4];
    int ipat [4];

    // ---------------- table: capture/full/overflow and restore bookkeeping
    tbl[0]  = mkv(0,1,1,0,0,0,0, 1,0,0,0,0);
    tbl[1]  = mkv(0,1,2,0,0,0,0, 2,0,0,0,0);
    tbl[2]  = mkv(0,1,3,0,0,0,0, 3,0,0,0,0);
    tbl[3]  = mkv(0,1,4,0,0,0,0, 0,1,0,0,0);
    tbl[4]  = mkv(0,1,5,0,0,0,0, 0,1,0,1,0);
    tbl[5]  = mkv(0,1,6,1,0,0,0, 1,1,0,1,0);
    tbl[6]  = mkv(1,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[7]  = mkv(0,1,7,0,0,0,0, 1,0,0,0,0);
    tbl[8]  = mkv(0,1,8,0,0,0,0, 2,0,0,0,0);
    tbl[9]  = mkv(0,1,9,0,0,0,0, 3,0,0,0,0);
    tbl[10] = mkv(0,1,10,0,0,0,0, 0,1,0,0,0);
    tbl[11] = mkv(0,0,0,0,1,1,0, 2,0,0,0,1);
    tbl[12] = mkv(0,0,0,0,1,3,0, 2,0,1,0,1);
    tbl[13] = mkv(0,0,0,0,0,0,0, 2,0,0,0,1);

    step();
    do_reset("reset_zero");
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst) begin
        clr();
        Rest = 1'b0; #1; Rest = 1'b1;
      end
      SNAPVALID = tbl[i].snap; SNAPPTR = tbl[i].sptr; SNAPLINES = mk_lines(int'(tbl[i].sptr));
      COMMIT = tbl[i].commit; RESTORE = tbl[i].rest; RESTOREID = tbl[i].rid;
      RESTREADY = tbl[i].rdy;
      step();
      check($sformatf("tbl%0d_snapid", i), 64'(SNAPID), 64'(tbl[i].e_id));
      check($sformatf("tbl%0d_full", i), 64'(CKPTFULL), 64'(tbl[i].e_full));
      check($sformatf("tbl%0d_err", i), 64'(RESTERR), 64'(tbl[i].e_err));
      check($sformatf("tbl%0d_ovf", i), 64'(OVERFLOW), 64'(tbl[i].e_ovf));
      check($sformatf("tbl%0d_vld", i), 64'(RESTVALID), 64'(tbl[i].e_vld));
    end
    clr();

    // ---------------- T2: single capture, full-rate restore latency
    do_reset("t2_reset");
    img = mk_lines(40);
    img[0 +: LW] = 39'h1_00001000;
    snap(3, img);
    RESTORE = 1'b1; RESTOREID = 2'd0; RESTREADY = 1'b1;
    step();
    RESTORE = 1'b0;
    check("t2_beat0_line", 64'(RESTLINE), 64'h1_00001000);
    for (int i = 0; i < LINES; i++) begin
      check($sformatf("t2_beat%0d", i), 64'({RESTVALID, RESTIDX, RESTLINE}),
            64'({1'b1, 4'(i), line_of(img, i)}));
      step();
    end
    check("t2_done", 64'({RESTDONE, RESTPTR, RESTVALID}), 64'({1'b1, 4'd3, 1'b0}));
    step();
    check("t2_idle", 64'({RESTDONE, RESTVALID}), 64'd0);

    // ---------------- T1: async reset mid-stream
    do_reset("t1_reset");
    snap(5, mk_lines(5));
    RESTORE = 1'b1; RESTOREID = 2'd0; RESTREADY = 1'b1;
    step();
    RESTORE = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("t1_at_beat5", 64'(RESTIDX), 64'd5);
    #2;
    Rest = 1'b0;
    #1;
    check("t1_async_zero", all_outs(), 64'd0);
    #1;
    Rest = 1'b1;
    step();
    RESTORE = 1'b1; RESTOREID = 2'd0;
    step();
    RESTORE = 1'b0;
    check("t1_err_after_reset", 64'({RESTERR, RESTVALID}), 64'({1'b1, 1'b0}));
    step();
    check("t1_err_pulse", 64'(RESTERR), 64'd0);

    // ---------------- T5: stall holds beat
    do_reset("t5_reset");
    img = mk_lines(9);
    snap(9, img);
    RESTORE = 1'b1; RESTOREID = 2'd0; RESTREADY = 1'b1;
    step();
    RESTORE = 1'b0;
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1};
    ipat = '{1, 1, 1, 2};
    for (int i = 0; i < 4; i++) begin
      RESTREADY = rpat[i][0];
      step();
      check($sformatf("t5_stall%0d", i), 64'({RESTVALID, RESTIDX, RESTLINE}),
            64'({1'b1, 4'(ipat[i]), line_of(img, ipat[i])}));
    end
    RESTREADY = 1'b1;
    n = 0;
    while (!RESTDONE && n < 40) begin step(); n++; end
    check("t5_done_cycles", 64'(n), 64'd13);

    // ---------------- T6: re-restore mid-stream
    do_reset("t6_reset");
    for (int i = 0; i < 4; i++) snap(i + 1, mk_lines(i + 1));
    RESTORE = 1'b1; RESTOREID = 2'd3; RESTREADY = 1'b1;
    step();
    RESTORE = 1'b0;
    n = 0;
    while (RESTIDX != 4'd7 && n < 20) begin step(); n++; end
    check("t6_reach_beat7", 64'({RESTIDX, RESTLINE}), 64'({4'd7, line_of(mk_lines(4), 7)}));
    RESTORE = 1'b1; RESTOREID = 2'd2;
    step();
    RESTORE = 1'b0;
    check("t6_restart", 64'({RESTVALID, RESTIDX, RESTLINE, RESTERR}),
          64'({1'b1, 4'd0, line_of(mk_lines(3), 0), 1'b0}));
    check("t6_wrptr", 64'(SNAPID), 64'd3);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (RESTDONE) begin
        dones++;
        check("t6_ptr", 64'(RESTPTR), 64'd3);
      end
      step();
    end
    check("t6_one_done", 64'(dones), 64'd1);

    // ---------------- random run vs queue model
    do_reset("rnd_reset");
    q.delete(); wr = 0; mode = 0; msel = 0; midx = 0; merr = 0; movf = 0;
    for (int c = 0; c < 3000; c++) begin
      bit sn, cm, re, rd;
      int rid, sp, pos;
      bit ok, prot, cme, capt, capok;
      logic [LINES*LW-1:0] li;

      check("rnd_ctl", 64'({SNAPID, CKPTFULL, RESTVALID, RESTDONE, RESTERR, OVERFLOW}),
            64'({2'(wr), q.size() == 4, mode == 1, mode == 2, merr, movf}));
      if (mode == 1)
        check("rnd_beat", 64'({RESTIDX, RESTLINE}), 64'({4'(midx), line_of(mimg[msel], midx)}));
      if (mode == 2)
        check("rnd_ptr", 64'(RESTPTR), 64'(mptr[msel]));

      re  = ($urandom_range(99) < 7);
      rid = int'($urandom_range(3));
      sn  = !re && ($urandom_range(99) < 40);
      cm  = !re && ($urandom_range(99) < 20);
      rd  = ($urandom_range(99) < 70);
      sp  = int'($urandom_range(15));
      li  = mk_lines(int'($urandom));
      SNAPVALID = sn; SNAPPTR = 4'(sp); SNAPLINES = li; COMMIT = cm;
      RESTORE = re; RESTOREID = 2'(rid); RESTREADY = rd;

      pos = -1;
      for (int k = 0; k < q.size(); k++) if (q[k] == rid) pos = k;
      ok = re && pos >= 0;
      merr = re && !ok;
      if (ok) begin
        while (q.size() > pos + 1) void'(q.pop_back());
        wr = (rid + 1) % 4;
      end
      prot  = ok ? (q[0] == rid) : (mode != 0 && q.size() > 0 && q[0] == msel);
      cme   = cm && q.size() > 0 && !prot;
      capt  = sn && mode == 0 && !ok;
      capok = capt && (q.size() < 4 || cme);
      if (cme) void'(q.pop_front());
      if (capok) begin
        mptr[wr] = 4'(sp); mimg[wr] = li; q.push_back(wr); wr = (wr + 1) % 4;
      end
      if (capt && !capok) movf = 1;
      if (ok) begin mode = 1; msel = rid; midx = 0; end
      else if (mode == 1 && rd) begin
        if (midx == LINES - 1) mode = 2; else midx++;
      end else if (mode == 2) mode = 0;
      step();
    end
    clr();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
